// File: rtl/tb_clock_monitor.sv
// rtl/tb_clock_monitor.sv - oversampling checker measuring high, low and period time of a monitored clock
// Ports:
//   CLK, RST_N            bench sampling clock, asynchronous active-low reset
//   EN                    run enable; its rising edge clears errors, edge_count and counters
//   MON_IN                monitored clock, asynchronous to CLK
//   per_min, per_max      inclusive legal period window (per_max = 0 disables the check)
//   high_min, high_max    inclusive legal high-time window (high_max = 0 disables the check)
//   high_cnt, low_cnt     last published high and low time in CLK cycles
//   period_cnt            high_cnt + low_cnt of the last published period
//   meas_valid            one-cycle pulse when a new measurement is published
//   err_period, err_high  sticky limit violations
//   err_stuck             sticky: no MON_IN edge for TIMEOUT cycles
//   edge_count            MON_IN rising edges seen while EN = 1 (wraps)
module tb_clock_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             MON_IN,
    input  logic [CNT_W:0]   per_min,
    input  logic [CNT_W:0]   per_max,
    input  logic [CNT_W-1:0] high_min,
    input  logic [CNT_W-1:0] high_max,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period_cnt,
    output logic             meas_valid,
    output logic             err_period,
    output logic             err_high,
    output logic             err_stuck,
    output logic [31:0]      edge_count
);

    localparam int SS     = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

    state_t            state;
    state_t            state_nx;
    logic [SS-1:0]     sync_q;
    logic              mon_s;
    logic              mon_d;
    logic              rise;
    logic              fall;
    logic              any_edge;
    logic              en_d;
    logic              en_rise;
    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  lcnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              timeout;
    logic              publish;
    logic [CNT_W:0]    pub_period;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign mon_s      = sync_q[SS-1];
    assign rise       = mon_s & ~mon_d;
    assign fall       = ~mon_s & mon_d;
    assign any_edge   = rise | fall;
    assign en_rise    = EN & ~en_d;
    // idle_cnt is cleared on the cycle an edge is detected, so reaching
    // TIMEOUT-1 here means TIMEOUT cycles have elapsed; a coincident edge wins.
    assign timeout    = EN && (state != S_IDLE) && !any_edge && (idle_cnt == IDLE_LAST);
    assign publish    = EN && (state == S_LOW) && rise;
    // hcnt is frozen while in LOW, so it still holds the high time here.
    assign pub_period = {1'b0, hcnt} + {1'b0, lcnt};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (!EN) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  state_nx = S_ARM;
                S_ARM:   if (rise) state_nx = S_HIGH;
                S_HIGH:  if (fall) state_nx = S_LOW;
                         else if (timeout) state_nx = S_ARM;
                S_LOW:   if (rise) state_nx = S_HIGH;
                         else if (timeout) state_nx = S_ARM;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q     <= '0;
            mon_d      <= 1'b0;
            en_d       <= 1'b0;
            hcnt       <= '0;
            lcnt       <= '0;
            idle_cnt   <= '0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            period_cnt <= '0;
            meas_valid <= 1'b0;
            err_period <= 1'b0;
            err_high   <= 1'b0;
            err_stuck  <= 1'b0;
            edge_count <= '0;
        end else begin
            sync_q     <= {sync_q[SS-2:0], MON_IN};
            mon_d      <= mon_s;
            en_d       <= EN;
            meas_valid <= publish;
            if (en_rise) begin
                // Measured outputs deliberately keep their last values.
                hcnt       <= '0;
                lcnt       <= '0;
                idle_cnt   <= '0;
                err_period <= 1'b0;
                err_high   <= 1'b0;
                err_stuck  <= 1'b0;
                edge_count <= '0;
            end else begin
                if (EN && rise) begin
                    edge_count <= edge_count + 32'd1;
                end
                if (!EN || (state == S_IDLE) || any_edge || timeout) begin
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
                if (timeout) begin
                    err_stuck <= 1'b1;
                end
                if (EN) begin
                    unique case (state)
                        S_ARM: begin
                            if (rise) hcnt <= CNT_W'(1);
                        end
                        S_HIGH: begin
                            if (fall) lcnt <= CNT_W'(1);
                            else      hcnt <= sat_inc(hcnt);
                        end
                        S_LOW: begin
                            if (rise) begin
                                high_cnt   <= hcnt;
                                low_cnt    <= lcnt;
                                period_cnt <= pub_period;
                                if ((per_max != '0) &&
                                    ((pub_period < per_min) || (pub_period > per_max))) begin
                                    err_period <= 1'b1;
                                end
                                if ((high_max != '0) &&
                                    ((hcnt < high_min) || (hcnt > high_max))) begin
                                    err_high <= 1'b1;
                                end
                                hcnt <= CNT_W'(1);
                            end else begin
                                lcnt <= sat_inc(lcnt);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_tb_clock_monitor.sv
// tb/tb_tb_clock_monitor.sv - self-checking bench for tb_clock_monitor against a waveform-level model
module tb_tb_clock_monitor;

    localparam int CNT_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 50;
    localparam int LAT         = SYNC_STAGES + 1;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             EN;
    logic             MON_IN;
    logic [CNT_W:0]   per_min;
    logic [CNT_W:0]   per_max;
    logic [CNT_W-1:0] high_min;
    logic [CNT_W-1:0] high_max;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic [CNT_W:0]   period_cnt;
    logic             meas_valid;
    logic             err_period;
    logic             err_high;
    logic             err_stuck;
    logic [31:0]      edge_count;

    always #5 CLK = ~CLK;

    tb_clock_monitor #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .EN         (EN),
        .MON_IN     (MON_IN),
        .per_min    (per_min),
        .per_max    (per_max),
        .high_min   (high_min),
        .high_max   (high_max),
        .high_cnt   (high_cnt),
        .low_cnt    (low_cnt),
        .period_cnt (period_cnt),
        .meas_valid (meas_valid),
        .err_period (err_period),
        .err_high   (err_high),
        .err_stuck  (err_stuck),
        .edge_count (edge_count)
    );

    typedef struct {
        int at;
        int h;
        int l;
        int edges;
    } ev_t;

    ev_t  evq[$];
    int   hist[$];
    int   cyc;
    int   total;
    int   fails;
    int   cur_h;
    int   cur_l;
    int   n_rise;
    logic en_m;
    logic armed;
    logic prev_lvl;
    logic exp_ep;
    logic exp_eh;
    logic exp_es;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_restart();
        armed  = 1'b0;
        cur_h  = 0;
        cur_l  = 0;
        n_rise = 0;
        exp_ep = 1'b0;
        exp_eh = 1'b0;
        exp_es = 1'b0;
        evq.delete();
        hist.delete();
        hist.push_back(cyc - SYNC_STAGES);
    endtask

    task automatic set_en(input logic v);
        EN   = v;
        en_m = v;
        if (v) begin
            model_restart();
        end else begin
            armed = 1'b0;
            cur_h = 0;
            cur_l = 0;
        end
    endtask

    task automatic tick(input logic lvl);
        logic exp_v;
        ev_t  ev;
        int   p;
        @(negedge CLK);
        cyc++;
        while (hist.size() > 1 && hist[1] <= cyc - LAT) hist.delete(0);
        if (en_m && hist.size() > 0 && hist[0] <= cyc - LAT &&
            cyc == hist[0] + LAT + TIMEOUT) begin
            exp_es  = 1'b1;
            armed   = 1'b0;
            cur_h   = 0;
            cur_l   = 0;
            hist[0] = cyc - LAT;
        end
        exp_v = (evq.size() > 0 && evq[0].at == cyc);
        check("meas_valid", 64'(meas_valid), 64'(exp_v));
        if (exp_v) begin
            ev = evq.pop_front();
            p  = ev.h + ev.l;
            if (int'(per_max) != 0 && (p < int'(per_min) || p > int'(per_max))) exp_ep = 1'b1;
            if (int'(high_max) != 0 && (ev.h < int'(high_min) || ev.h > int'(high_max))) exp_eh = 1'b1;
            check("high_cnt", 64'(high_cnt), 64'(ev.h));
            check("low_cnt", 64'(low_cnt), 64'(ev.l));
            check("period_cnt", 64'(period_cnt), 64'(p));
            check("edge_count_at_meas", 64'(edge_count), 64'(ev.edges));
        end
        check("err_period", 64'(err_period), 64'(exp_ep));
        check("err_high", 64'(err_high), 64'(exp_eh));
        check("err_stuck", 64'(err_stuck), 64'(exp_es));
        if (lvl != prev_lvl) begin
            if (en_m) hist.push_back(cyc);
            if (lvl) begin
                if (en_m) begin
                    n_rise++;
                    if (armed && cur_h > 0 && cur_l > 0) begin
                        evq.push_back('{cyc + LAT, cur_h, cur_l, n_rise});
                    end
                    armed = 1'b1;
                    cur_h = 1;
                    cur_l = 0;
                end
            end else if (armed) begin
                cur_l = 1;
            end
        end else if (armed) begin
            if (lvl) cur_h++;
            else     cur_l++;
        end
        MON_IN   = lvl;
        prev_lvl = lvl;
    endtask

    task automatic seg(input int h, input int l);
        repeat (h) tick(1'b1);
        repeat (l) tick(1'b0);
    endtask

    task automatic reset_pulse();
        #2 RST_N = 1'b0;
        #1;
        check("rst_high_cnt", 64'(high_cnt), 64'd0);
        check("rst_low_cnt", 64'(low_cnt), 64'd0);
        check("rst_period_cnt", 64'(period_cnt), 64'd0);
        check("rst_meas_valid", 64'(meas_valid), 64'd0);
        check("rst_err_period", 64'(err_period), 64'd0);
        check("rst_err_high", 64'(err_high), 64'd0);
        check("rst_err_stuck", 64'(err_stuck), 64'd0);
        check("rst_edge_count", 64'(edge_count), 64'd0);
        RST_N = 1'b1;
        model_restart();
    endtask

    initial begin
        RST_N    = 1'b0;
        EN       = 1'b0;
        MON_IN   = 1'b0;
        per_min  = '0;
        per_max  = '0;
        high_min = '0;
        high_max = '0;
        cyc      = 0;
        total    = 0;
        fails    = 0;
        en_m     = 1'b0;
        prev_lvl = 1'b0;
        model_restart();

        repeat (2) @(negedge CLK);
        check("init_high_cnt", 64'(high_cnt), 64'd0);
        check("init_period_cnt", 64'(period_cnt), 64'd0);
        check("init_meas_valid", 64'(meas_valid), 64'd0);
        check("init_err_stuck", 64'(err_stuck), 64'd0);
        check("init_edge_count", 64'(edge_count), 64'd0);
        RST_N = 1'b1;
        repeat (3) tick(1'b0);

        // Basic 4/6 measurement, no limits
        set_en(1'b1);
        repeat (3) tick(1'b0);
        repeat (4) seg(4, 6);
        tick(1'b0);

        // Period window 11..20 violated by period 10, then legal period 15
        set_en(1'b0);
        per_min = 17'd11;
        per_max = 17'd20;
        repeat (4) tick(1'b0);
        set_en(1'b1);
        repeat (3) tick(1'b0);
        repeat (3) seg(4, 6);
        repeat (3) seg(7, 8);
        check("t2_err_period_sticky", 64'(err_period), 64'd1);

        // EN dropped mid-HIGH, then re-enabled
        repeat (5) tick(1'b1);
        set_en(1'b0);
        repeat (3) tick(1'b1);
        repeat (5) tick(1'b0);
        set_en(1'b1);
        tick(1'b0);
        check("t4_edge_count_cleared", 64'(edge_count), 64'd0);
        check("t4_err_period_cleared", 64'(err_period), 64'd0);
        repeat (2) tick(1'b0);
        repeat (3) seg(4, 6);

        // Randomised periods with period and high-time windows
        set_en(1'b0);
        per_min  = 17'd6;
        per_max  = 17'd18;
        high_min = 16'd2;
        high_max = 16'd9;
        repeat (4) tick(1'b0);
        set_en(1'b1);
        repeat (3) tick(1'b0);
        for (int i = 0; i < 40; i++) begin
            seg(int'($urandom_range(12, 1)), int'($urandom_range(12, 1)));
        end

        // Randomised periods with all checks disabled, then period-2 toggling
        set_en(1'b0);
        per_min  = '0;
        per_max  = '0;
        high_min = '0;
        high_max = '0;
        repeat (4) tick(1'b0);
        set_en(1'b1);
        repeat (3) tick(1'b0);
        for (int i = 0; i < 20; i++) begin
            seg(int'($urandom_range(12, 1)), int'($urandom_range(12, 1)));
        end
        repeat (12) seg(1, 1);
        repeat (4) tick(1'b0);
        check("edge_count_total", 64'(edge_count), 64'(n_rise));

        // Stall: MON_IN held high after a rising edge
        repeat (60) tick(1'b1);
        check("t3_err_stuck", 64'(err_stuck), 64'd1);
        repeat (5) tick(1'b0);
        repeat (3) seg(3, 5);

        // Asynchronous reset in the middle of a low phase
        repeat (2) seg(4, 6);
        repeat (4) tick(1'b1);
        repeat (3) tick(1'b0);
        reset_pulse();
        repeat (3) tick(1'b0);
        repeat (3) seg(4, 6);
        repeat (4) tick(1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
